ifm_tile_controller: RTL and testbench
======================================

IFM_TILE_CONTROLLER -- requirements
Module: ifm_tile_controller

Interface
REQ-001 SHALL have parameter TILE_W, default 13: ifm columns per tile.
REQ-002 SHALL have parameter W_BITS, default 9: width of ifm width/height fields.
REQ-003 SHALL have parameter C_BITS, default 11: width of channel fields.
REQ-004 SHALL have parameter T_BITS, default 6: width of tile index.
REQ-005 SHALL have parameter TC_BITS, default 4: width of tile_cols.
REQ-006 SHALL have port clk, input, 1 bit: the only clock, rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-008 SHALL have port start, input, 1 bit: begin layer; sampled only in IDLE.
REQ-009 SHALL have port cfg_width, input, W_BITS: ifm width, which equals ifm height.
REQ-010 SHALL have ports cfg_in_ch and cfg_out_ch, input, C_BITS each: input and output channel counts.
REQ-011 SHALL have port cfg_kernel3, input, 1 bit: 1 = 3x3 convolution, 0 = 1x1 convolution.
REQ-012 SHALL have port ifm_hs, input, 1 bit: one accepted ifm beat, i.e. one (tile, channel) unit.
REQ-013 SHALL have port bram_hs, input, 1 bit: one accepted last-row replay beat.
REQ-014 SHALL have ports busy and done, output, 1 bit each: busy = not IDLE; done = one-cycle completion pulse.
REQ-015 SHALL have ports row_first, row_reuse and row_last, output, 1 bit each: state decodes.
REQ-016 SHALL have port last_col, output, 1 bit: ifm_hs qualified by w_cnt==w_last and c_cnt==cfg_in_ch-1.
REQ-017 SHALL have ports w_cnt (T_BITS), h_cnt (W_BITS), c_cnt (C_BITS) and ofm_cnt (C_BITS), output: position counters.
REQ-018 SHALL have port tile_cols, output, TC_BITS: valid columns in the current tile.
REQ-019 SHALL have ports pad_top, pad_bot, pad_left and pad_right, output, 1 bit each: zero-padding flags.
REQ-020 SHALL have port cfg_err, output, 1 bit: one-cycle configuration error pulse.

Function
REQ-021 SHALL implement states IDLE, CALC, FIRST, REUSE, LAST and DONE.
REQ-022 IDLE SHALL latch all cfg_* inputs and move to CALC when start is high; start outside IDLE SHALL be ignored.
REQ-023 CALC SHALL compute w_last = ceil(cfg_width/TILE_W)-1 and rem = cfg_width-w_last*TILE_W by repeated subtraction of TILE_W, one per cycle, lasting ceil(cfg_width/TILE_W) cycles, then SHALL enter FIRST.
REQ-024 ifm_hs SHALL advance counters only in FIRST and REUSE; bram_hs SHALL advance counters only in LAST; both SHALL be ignored in every other state.
REQ-025 On each counted beat c_cnt SHALL increment, wrapping at cfg_in_ch-1; on each wrap w_cnt SHALL increment, wrapping at w_last.
REQ-026 On last_col in FIRST: with cfg_kernel3=1, h_cnt SHALL be set to 2 and the state SHALL become REUSE; with cfg_kernel3=0, h_cnt SHALL be set to 1, and the state SHALL become REUSE, or wrap-up if cfg_width==1.
REQ-027 On last_col in REUSE with h_cnt==cfg_width-1: with cfg_kernel3=1 the state SHALL become LAST; otherwise wrap-up; in all other REUSE cases h_cnt SHALL increment.
REQ-028 LAST SHALL count w_last+1 times cfg_in_ch bram_hs beats using the same c_cnt and w_cnt, then wrap-up.
REQ-029 Wrap-up SHALL clear h_cnt, w_cnt and c_cnt; if ofm_cnt==cfg_out_ch-1 it SHALL clear ofm_cnt and enter DONE; otherwise it SHALL increment ofm_cnt and enter FIRST.
REQ-030 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-031 tile_cols SHALL be rem when w_cnt==w_last, TILE_W otherwise, and 0 in IDLE and CALC.
REQ-032 With cfg_kernel3=1: pad_top SHALL equal row_first, pad_bot SHALL equal row_last, pad_left SHALL be high when (w_cnt==0)&busy, and pad_right SHALL be high when (w_cnt==w_last)&busy; all pad flags SHALL be 0 when cfg_kernel3=0.
REQ-033 All outputs SHALL be registered except last_col and the decodes of state and counters.

Reset
REQ-034 rst_n low SHALL, at any time including mid-layer, immediately force IDLE and clear every counter, done, cfg_err, w_last and rem.
REQ-035 During reset all outputs SHALL be 0.
REQ-036 The first start after reset deassertion SHALL be honoured.

Configuration
REQ-037 Macro IFM_TILE_CFG_CHECK_EN, when defined, SHALL make start with any of cfg_width, cfg_in_ch or cfg_out_ch equal to 0 pulse cfg_err for one cycle and remain in IDLE.
REQ-038 When IFM_TILE_CFG_CHECK_EN is undefined, cfg_err SHALL be tied to 0 and zero configurations SHALL be unsupported.

Verification
REQ-039 width=13, in_ch=1, out_ch=2, kernel3=1 -> per ofm pass 1 FIRST beat, 11 REUSE beats and 1 LAST bram_hs beat; exactly one done pulse after 24 ifm_hs and 2 bram_hs.
REQ-040 width=416, in_ch=2, kernel3=1 -> CALC lasts 32 cycles, w_last=31, tile_cols=13 throughout, FIRST ends after 64 beats with h_cnt=2.
REQ-041 width=20, in_ch=1 -> w_last=1, tile_cols toggles 13/7, and pad_right is high only on the tile 1 beat.
REQ-042 width=26, in_ch=3, out_ch=1, kernel3=0 -> 156 ifm_hs beats then done, with no LAST state and all pad flags 0.
REQ-043 rst_n pulsed low mid-REUSE -> all outputs 0 at once; a new start with width=13 produces a normal complete run.
REQ-044 With IFM_TILE_CFG_CHECK_EN defined, start with in_ch=0 -> one cfg_err pulse and busy stays 0.

Source files
------------

// File: rtl/ifm_tile_controller.sv
// ifm_tile_controller
// Sequences the input feature map through column tiles, channels and rows
// for every output channel of a convolution layer.
//   CALC  : splits cfg_width into tiles of TILE_W columns (last tile may be short)
//   FIRST : first row(s) of the ifm, streamed from the ifm port
//   REUSE : remaining rows, streamed from the ifm port
//   LAST  : 3x3 only, last row replayed from BRAM
// Optional build macro IFM_TILE_CFG_CHECK_EN: rejects a start whose width or
// channel counts are zero by pulsing cfg_err and staying idle. Without it,
// cfg_err is tied low and zero configurations are unsupported.
module ifm_tile_controller #(
  parameter int TILE_W  = 13,
  parameter int W_BITS  = 9,
  parameter int C_BITS  = 11,
  parameter int T_BITS  = 6,
  parameter int TC_BITS = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [W_BITS-1:0]  cfg_width,
  input  logic [C_BITS-1:0]  cfg_in_ch,
  input  logic [C_BITS-1:0]  cfg_out_ch,
  input  logic               cfg_kernel3,
  input  logic               ifm_hs,
  input  logic               bram_hs,
  output logic               busy,
  output logic               done,
  output logic               row_first,
  output logic               row_reuse,
  output logic               row_last,
  output logic               last_col,
  output logic [T_BITS-1:0]  w_cnt,
  output logic [W_BITS-1:0]  h_cnt,
  output logic [C_BITS-1:0]  c_cnt,
  output logic [C_BITS-1:0]  ofm_cnt,
  output logic [TC_BITS-1:0] tile_cols,
  output logic               pad_top,
  output logic               pad_bot,
  output logic               pad_left,
  output logic               pad_right,
  output logic               cfg_err
);

  localparam logic [W_BITS-1:0]  TILE_W_W  = W_BITS'(TILE_W);
  localparam logic [TC_BITS-1:0] TILE_W_TC = TC_BITS'(TILE_W);

  typedef enum logic [2:0] {IDLE, CALC, FIRST, REUSE, LAST, DONE} state_t;

  state_t             state;
  logic [W_BITS-1:0]  width_q;
  logic [C_BITS-1:0]  in_ch_q;
  logic [C_BITS-1:0]  out_ch_q;
  logic               kernel3_q;
  logic [T_BITS-1:0]  w_last;
  logic [W_BITS-1:0]  rem;

  logic row_active;
  logic beat;
  logic c_wrap;
  logic w_wrap;
  logic row_end;
  logic wrap_up;

  assign row_active = (state == FIRST) || (state == REUSE);
  assign beat       = (ifm_hs && row_active) || (bram_hs && (state == LAST));
  assign c_wrap     = (c_cnt == (in_ch_q - C_BITS'(1)));
  assign w_wrap     = (w_cnt == w_last);
  assign row_end    = beat && c_wrap && w_wrap;
  assign last_col   = ifm_hs && row_active && c_wrap && w_wrap;

  // A row ends the current ofm pass when no further rows need streaming.
  assign wrap_up = row_end &&
                   (((state == FIRST) && !kernel3_q && (width_q == W_BITS'(1))) ||
                    ((state == REUSE) && !kernel3_q && (h_cnt == (width_q - W_BITS'(1)))) ||
                    (state == LAST));

  assign busy      = (state != IDLE);
  assign row_first = (state == FIRST);
  assign row_reuse = (state == REUSE);
  assign row_last  = (state == LAST);

  assign pad_top   = kernel3_q && row_first;
  assign pad_bot   = kernel3_q && row_last;
  assign pad_left  = kernel3_q && busy && (w_cnt == '0);
  assign pad_right = kernel3_q && busy && w_wrap;

  // Column count of the tile currently being streamed; the last tile holds the remainder.
  always_comb begin
    tile_cols = '0;
    if ((state != IDLE) && (state != CALC)) begin
      tile_cols = w_wrap ? rem[TC_BITS-1:0] : TILE_W_TC;
    end
  end

`ifndef IFM_TILE_CFG_CHECK_EN
  assign cfg_err = 1'b0;
`endif

  // Layer sequencer: config latch, tile split, row/column/channel counters and ofm loop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      width_q   <= '0;
      in_ch_q   <= '0;
      out_ch_q  <= '0;
      kernel3_q <= 1'b0;
      w_last    <= '0;
      rem       <= '0;
      w_cnt     <= '0;
      h_cnt     <= '0;
      c_cnt     <= '0;
      ofm_cnt   <= '0;
      done      <= 1'b0;
`ifdef IFM_TILE_CFG_CHECK_EN
      cfg_err   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef IFM_TILE_CFG_CHECK_EN
      cfg_err <= 1'b0;
`endif

      if (beat) begin
        if (c_wrap) begin
          c_cnt <= '0;
          w_cnt <= w_wrap ? '0 : (w_cnt + T_BITS'(1));
        end else begin
          c_cnt <= c_cnt + C_BITS'(1);
        end
      end

      case (state)
        IDLE: begin
          if (start) begin
            width_q   <= cfg_width;
            in_ch_q   <= cfg_in_ch;
            out_ch_q  <= cfg_out_ch;
            kernel3_q <= cfg_kernel3;
`ifdef IFM_TILE_CFG_CHECK_EN
            if ((cfg_width == '0) || (cfg_in_ch == '0) || (cfg_out_ch == '0)) begin
              cfg_err <= 1'b1;
            end else begin
              rem    <= cfg_width;
              w_last <= '0;
              state  <= CALC;
            end
`else
            rem    <= cfg_width;
            w_last <= '0;
            state  <= CALC;
`endif
          end
        end
        CALC: begin
          if (rem > TILE_W_W) begin
            rem    <= rem - TILE_W_W;
            w_last <= w_last + T_BITS'(1);
          end else begin
            state <= FIRST;
          end
        end
        FIRST: begin
          if (row_end) begin
            h_cnt <= kernel3_q ? W_BITS'(2) : W_BITS'(1);
            state <= REUSE;
          end
        end
        REUSE: begin
          if (row_end) begin
            if (h_cnt == (width_q - W_BITS'(1))) begin
              if (kernel3_q) begin
                state <= LAST;
              end
            end else begin
              h_cnt <= h_cnt + W_BITS'(1);
            end
          end
        end
        LAST: begin
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase

      if (wrap_up) begin
        h_cnt <= '0;
        w_cnt <= '0;
        c_cnt <= '0;
        if (ofm_cnt == (out_ch_q - C_BITS'(1))) begin
          ofm_cnt <= '0;
          done    <= 1'b1;
          state   <= DONE;
        end else begin
          ofm_cnt <= ofm_cnt + C_BITS'(1);
          state   <= FIRST;
        end
      end
    end
  end

endmodule

// File: tb/tb_ifm_tile_controller.sv
// Directed testbench for ifm_tile_controller with hand-computed expectations.
module tb_ifm_tile_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [8:0]  cfg_width = '0;
  logic [10:0] cfg_in_ch = '0;
  logic [10:0] cfg_out_ch = '0;
  logic        cfg_kernel3 = 1'b0;
  logic        ifm_hs = 1'b0;
  logic        bram_hs = 1'b0;
  logic        busy, done, row_first, row_reuse, row_last, last_col;
  logic [5:0]  w_cnt;
  logic [8:0]  h_cnt;
  logic [10:0] c_cnt, ofm_cnt;
  logic [3:0]  tile_cols;
  logic        pad_top, pad_bot, pad_left, pad_right, cfg_err;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  logic lc_seen = 1'b0;

  ifm_tile_controller dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .cfg_width(cfg_width), .cfg_in_ch(cfg_in_ch), .cfg_out_ch(cfg_out_ch),
    .cfg_kernel3(cfg_kernel3), .ifm_hs(ifm_hs), .bram_hs(bram_hs),
    .busy(busy), .done(done), .row_first(row_first), .row_reuse(row_reuse),
    .row_last(row_last), .last_col(last_col), .w_cnt(w_cnt), .h_cnt(h_cnt),
    .c_cnt(c_cnt), .ofm_cnt(ofm_cnt), .tile_cols(tile_cols),
    .pad_top(pad_top), .pad_bot(pad_bot), .pad_left(pad_left),
    .pad_right(pad_right), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One handshake beat; records last_col during the beat and any done pulse after it.
  task automatic apply_stimulus(input bit use_bram);
    ifm_hs  = !use_bram;
    bram_hs = use_bram;
    #1;
    lc_seen = last_col;
    @(posedge clk);
    #1;
    ifm_hs  = 1'b0;
    bram_hs = 1'b0;
    if (done) done_cnt++;
  endtask

  task automatic start_layer(input int w, input int ic, input int oc, input bit k3);
    cfg_width   = 9'(w);
    cfg_in_ch   = 11'(ic);
    cfg_out_ch  = 11'(oc);
    cfg_kernel3 = k3;
    start = 1'b1;
    tick();
    start = 1'b0;
    done_cnt = 0;
  endtask

  task automatic wait_first(output int cycles);
    cycles = 0;
    while (!row_first && cycles < 200) begin
      tick();
      cycles++;
    end
  endtask

  initial begin
    int cyc;
    int n;
    bit tile_ok;
    bit saw_last;
    bit pad_seen;

    // Reset state
    tick(); tick();
    check_output("rst_busy", busy, 0);
    check_output("rst_done", done, 0);
    check_output("rst_tile_cols", tile_cols, 0);
    check_output("rst_pads", {pad_top, pad_bot, pad_left, pad_right}, 0);
    check_output("rst_counters", {w_cnt, h_cnt, c_cnt, ofm_cnt}, 0);
    check_output("rst_cfg_err", cfg_err, 0);
    rst_n = 1'b1;
    tick();

    // width 13, in 1, out 2, 3x3
    start_layer(13, 1, 2, 1);
    check_output("a_calc_busy", busy, 1);
    check_output("a_calc_tile_cols", tile_cols, 0);
    wait_first(cyc);
    check_output("a_calc_cycles", cyc, 1);
    check_output("a_first_tile_cols", tile_cols, 13);
    check_output("a_first_pads", {pad_top, pad_bot, pad_left, pad_right}, 4'b1011);
    for (int p = 0; p < 2; p++) begin
      apply_stimulus(0);
      check_output("a_first_last_col", lc_seen, 1);
      check_output("a_reuse_state", row_reuse, 1);
      check_output("a_reuse_h", h_cnt, 2);
      if (p == 0) begin
        start = 1'b1;
        tick();
        start = 1'b0;
        check_output("a_start_ignored", {row_reuse, h_cnt}, {1'b1, 9'd2});
        apply_stimulus(1);
        check_output("a_bram_ignored_reuse", {row_reuse, h_cnt}, {1'b1, 9'd2});
      end
      for (int i = 0; i < 11; i++) apply_stimulus(0);
      check_output("a_last_state", row_last, 1);
      check_output("a_last_pads", {pad_top, pad_bot}, 2'b01);
      check_output("a_last_h", h_cnt, 12);
      if (p == 0) begin
        apply_stimulus(0);
        check_output("a_ifm_ignored_last", row_last, 1);
      end
      apply_stimulus(1);
      if (p == 0) begin
        check_output("a_next_ofm_first", row_first, 1);
        check_output("a_next_ofm_cnt", ofm_cnt, 1);
        check_output("a_next_ofm_h", h_cnt, 0);
      end
    end
    check_output("a_done_pulse", done, 1);
    check_output("a_ofm_cleared", ofm_cnt, 0);
    tick();
    check_output("a_done_count", done_cnt, 1);
    check_output("a_idle_after", {busy, done}, 0);

    // width 20, in 1, out 1, 3x3: short second tile
    start_layer(20, 1, 1, 1);
    wait_first(cyc);
    check_output("c_calc_cycles", cyc, 2);
    check_output("c_t0_tile_cols", tile_cols, 13);
    check_output("c_t0_pads", {pad_left, pad_right}, 2'b10);
    apply_stimulus(0);
    check_output("c_t0_last_col", lc_seen, 0);
    check_output("c_t1_w", w_cnt, 1);
    check_output("c_t1_tile_cols", tile_cols, 7);
    check_output("c_t1_pads", {pad_left, pad_right}, 2'b01);
    apply_stimulus(0);
    check_output("c_t1_last_col", lc_seen, 1);
    check_output("c_reuse_t0", {row_reuse, tile_cols, pad_right}, {1'b1, 4'd13, 1'b0});
    for (int i = 0; i < 36; i++) apply_stimulus(0);
    check_output("c_last_state", row_last, 1);
    apply_stimulus(1);
    apply_stimulus(1);
    check_output("c_done_pulse", {done, done_cnt[0]}, 2'b11);
    tick();

    // width 26, in 3, out 1, 1x1
    start_layer(26, 3, 1, 0);
    wait_first(cyc);
    check_output("d_calc_cycles", cyc, 2);
    n = 0;
    saw_last = 0;
    pad_seen = 0;
    while (!done && n < 400) begin
      if (row_last) saw_last = 1;
      if (pad_top || pad_bot || pad_left || pad_right) pad_seen = 1;
      apply_stimulus(0);
      n++;
    end
    check_output("d_beats", n, 156);
    check_output("d_no_last", saw_last, 0);
    check_output("d_no_pads", pad_seen, 0);
    check_output("d_done_count", done_cnt, 1);
    tick();

    // width 416, in 2, out 1, 3x3; aborted by reset mid-REUSE
    start_layer(416, 2, 1, 1);
    check_output("b_calc_tile_cols", tile_cols, 0);
    wait_first(cyc);
    check_output("b_calc_cycles", cyc, 32);
    tile_ok = 1;
    for (int i = 0; i < 64; i++) begin
      if (tile_cols !== 4'd13) tile_ok = 0;
      if (i == 63) check_output("b_pre_last_pos", {w_cnt, c_cnt}, {6'd31, 11'd1});
      apply_stimulus(0);
    end
    check_output("b_last_col", lc_seen, 1);
    check_output("b_tile_cols_13", tile_ok, 1);
    check_output("b_first_end_h", h_cnt, 2);
    check_output("b_reuse_state", row_reuse, 1);
    for (int i = 0; i < 3; i++) apply_stimulus(0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_output("r_busy", {busy, done, row_first, row_reuse, row_last, cfg_err}, 0);
    check_output("r_counters", {w_cnt, h_cnt, c_cnt, ofm_cnt}, 0);
    check_output("r_tile_pads", {tile_cols, pad_top, pad_bot, pad_left, pad_right}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    // width 13, in 1, out 1 after reset
    start_layer(13, 1, 1, 1);
    wait_first(cyc);
    check_output("e_calc_cycles", cyc, 1);
    for (int i = 0; i < 12; i++) apply_stimulus(0);
    check_output("e_last_state", row_last, 1);
    apply_stimulus(1);
    check_output("e_done", {done, done_cnt[0]}, 2'b11);
    tick();
    check_output("e_idle", busy, 0);

`ifdef IFM_TILE_CFG_CHECK_EN
    start_layer(13, 0, 1, 1);
    check_output("g_cfg_err_pulse", {cfg_err, busy}, 2'b10);
    tick();
    check_output("g_cfg_err_clear", {cfg_err, busy}, 2'b00);
`else
    check_output("g_cfg_err_tied", cfg_err, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
